rx_frame_gate: RTL and testbench

Store-and-forward gate directly downstream of the Ethernet/UDP payload receiver. Buffers each received payload frame (AXI-Stream bytes with `tlast`) and releases it to the consumer only after a per-frame status strobe reports a good FCS. Frames with a CRC error or a buffer overflow are rolled back and never appear on the output. It keeps saturating good/bad/overflow frame counters for the register map.

---
 rtl/rx_frame_gate_if.sv | 12 +
 rtl/rx_frame_gate.sv | 129 ++++++++++++
 tb/tb_rx_frame_gate.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_gate_if.sv
// AXI-Stream byte interface used on both sides of the frame gate.
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rx_frame_gate.sv
// Store-and-forward gate: buffers each received frame and releases it only
// after a good-FCS status strobe; bad or overflowed frames are rolled back.
module rx_frame_gate #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axis_if.slave                s_axis,
    input  logic                 status_valid_i,
    input  logic                 status_err_i,
    axis_if.master               m_axis,
    output logic                 frame_ok_o,
    output logic                 frame_drop_o,
    output logic [CNT_WIDTH-1:0] cnt_ok_o,
    output logic [CNT_WIDTH-1:0] cnt_crc_o,
    output logic [CNT_WIDTH-1:0] cnt_ovf_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        RECV,
        WAIT_STATUS
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH:0]   commit_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic                  ovf_q;
    logic                  frame_ok_q;
    logic                  frame_drop_q;
    logic [CNT_WIDTH-1:0]  cnt_ok_q;
    logic [CNT_WIDTH-1:0]  cnt_crc_q;
    logic [CNT_WIDTH-1:0]  cnt_ovf_q;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];

    logic full;
    logic in_fire;
    logic wr_en;
    logic rd_fire;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Full uses registered pointers only, so a same-cycle read never frees room for this write.
    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_PTR;
    assign s_axis.tready = (state_q == RECV) && !rst_i;
    assign in_fire = s_axis.tvalid && s_axis.tready;
    assign wr_en   = in_fire && !full && !ovf_q;

    assign m_axis.tvalid = (rd_ptr_q != commit_ptr_q);
    assign {m_axis.tlast, m_axis.tdata} = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_fire = m_axis.tvalid && m_axis.tready;

    // NOTE: the buffer has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            cnt_ok_q     <= '0;
            cnt_crc_q    <= '0;
            cnt_ovf_q    <= '0;
        end else begin
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;

            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                RECV: begin
                    if (in_fire) begin
                        if (wr_en) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (s_axis.tlast) begin
                            state_q <= WAIT_STATUS;
                        end
                    end
                end
                WAIT_STATUS: begin
                    if (status_valid_i) begin
                        // Overflow outranks a CRC error when both apply.
                        if (ovf_q) begin
                            wr_ptr_q     <= commit_ptr_q;
                            cnt_ovf_q    <= sat_inc(cnt_ovf_q);
                            frame_drop_q <= 1'b1;
                        end else if (status_err_i) begin
                            wr_ptr_q     <= commit_ptr_q;
                            cnt_crc_q    <= sat_inc(cnt_crc_q);
                            frame_drop_q <= 1'b1;
                        end else begin
                            commit_ptr_q <= wr_ptr_q;
                            cnt_ok_q     <= sat_inc(cnt_ok_q);
                            frame_ok_q   <= 1'b1;
                        end
                        ovf_q   <= 1'b0;
                        state_q <= RECV;
                    end
                end
                default: state_q <= RECV;
            endcase
        end
    end

    assign frame_ok_o   = frame_ok_q;
    assign frame_drop_o = frame_drop_q;
    assign cnt_ok_o     = cnt_ok_q;
    assign cnt_crc_o    = cnt_crc_q;
    assign cnt_ovf_o    = cnt_ovf_q;
endmodule

// File: tb/tb_rx_frame_gate.sv
// Directed bench for rx_frame_gate with a 16-entry buffer and 2-bit counters.
module tb_rx_frame_gate;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       status_valid_i;
    logic       status_err_i;
    logic       frame_ok_o;
    logic       frame_drop_o;
    logic [1:0] cnt_ok_o;
    logic [1:0] cnt_crc_o;
    logic [1:0] cnt_ovf_o;

    int checks = 0;
    int errors = 0;
    int start;
    logic [8:0] rx_q [$];

    axis_if #(.DATA_WIDTH(8)) s_if ();
    axis_if #(.DATA_WIDTH(8)) m_if ();

    rx_frame_gate #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .CNT_WIDTH (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_axis        (s_if),
        .status_valid_i(status_valid_i),
        .status_err_i  (status_err_i),
        .m_axis        (m_if),
        .frame_ok_o    (frame_ok_o),
        .frame_drop_o  (frame_drop_o),
        .cnt_ok_o      (cnt_ok_o),
        .cnt_crc_o     (cnt_crc_o),
        .cnt_ovf_o     (cnt_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Records every beat the consumer takes.
    always @(posedge clk_i) begin
        if (!rst_i && m_if.tvalid && m_if.tready) begin
            rx_q.push_back({m_if.tlast, m_if.tdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_in_ready", 32'(s_if.tready), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_release_ready", 32'(s_if.tready), 1);
        check("rst_out_valid", 32'(m_if.tvalid), 0);
        check("rst_pulses", {frame_ok_o, frame_drop_o}, 0);
        check("rst_counters", {cnt_ok_o, cnt_crc_o, cnt_ovf_o}, 0);
    endtask

    task automatic send_frame(input logic [7:0] base, input int len,
                              input bit with_last, input bit strobe_on_last);
        int n;
        for (int i = 0; i < len; i++) begin
            n = 0;
            while (!s_if.tready && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            check("in_ready", 32'(s_if.tready), 1);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(base + 8'(i));
            s_if.tlast  = with_last && (i == len - 1);
            if (strobe_on_last && i == len - 1) begin
                status_valid_i = 1'b1;
                status_err_i   = 1'b0;
            end
            @(negedge clk_i);
        end
        s_if.tvalid    = 1'b0;
        s_if.tlast     = 1'b0;
        status_valid_i = 1'b0;
    endtask

    task automatic strobe(input bit err);
        status_valid_i = 1'b1;
        status_err_i   = err;
        @(negedge clk_i);
        status_valid_i = 1'b0;
        status_err_i   = 1'b0;
    endtask

    // Frames of flen bytes; each frame's bytes start 0x10 above the previous one.
    task automatic expect_beats(input int first, input logic [7:0] base,
                                input int len, input int flen);
        int n;
        logic [8:0] exp_beat;
        n = 0;
        while (rx_q.size() < first + len && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("beat_count", 32'(rx_q.size()), 32'(first + len));
        for (int i = 0; i < len && first + i < rx_q.size(); i++) begin
            exp_beat = {((i % flen) == flen - 1), 8'(32'(base) + (i / flen) * 16 + (i % flen))};
            check("beat", 32'(rx_q[first + i]), 32'(exp_beat));
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        status_valid_i = 1'b0;
        status_err_i   = 1'b0;
        s_if.tvalid    = 1'b0;
        s_if.tdata     = '0;
        s_if.tlast     = 1'b0;
        m_if.tready    = 1'b1;

        do_reset();

        // Good 5-byte frame, status three cycles after the last beat.
        start = rx_q.size();
        send_frame(8'h11, 5, 1'b1, 1'b0);
        check("g_ready_after_last", 32'(s_if.tready), 0);
        tick(2);
        check("g_valid_before", 32'(m_if.tvalid), 0);
        strobe(1'b0);
        check("g_ok_pulse", {frame_ok_o, frame_drop_o}, 2'b10);
        check("g_cnt_ok", 32'(cnt_ok_o), 1);
        check("g_valid_after", 32'(m_if.tvalid), 1);
        check("g_first_data", {m_if.tlast, m_if.tdata}, 9'h011);
        check("g_ready_back", 32'(s_if.tready), 1);
        tick(1);
        check("g_ok_one_cycle", 32'(frame_ok_o), 0);
        expect_beats(start, 8'h11, 5, 5);

        // CRC error frame is dropped, next good frame passes intact.
        start = rx_q.size();
        send_frame(8'h21, 4, 1'b1, 1'b0);
        strobe(1'b1);
        check("c_drop_pulse", {frame_ok_o, frame_drop_o}, 2'b01);
        check("c_cnt_crc", 32'(cnt_crc_o), 1);
        check("c_cnt_ok", 32'(cnt_ok_o), 1);
        check("c_no_valid", 32'(m_if.tvalid), 0);
        send_frame(8'h31, 3, 1'b1, 1'b0);
        strobe(1'b0);
        check("c_cnt_ok2", 32'(cnt_ok_o), 2);
        expect_beats(start, 8'h31, 3, 3);

        // Overflow: 20 bytes into 16 entries, no input stall, overflow beats CRC.
        do_reset();
        start = rx_q.size();
        send_frame(8'h40, 20, 1'b1, 1'b0);
        strobe(1'b1);
        check("o_drop_pulse", {frame_ok_o, frame_drop_o}, 2'b01);
        check("o_cnt_ovf", 32'(cnt_ovf_o), 1);
        check("o_cnt_crc", 32'(cnt_crc_o), 0);
        check("o_no_valid", 32'(m_if.tvalid), 0);
        send_frame(8'h60, 16, 1'b1, 1'b0);
        strobe(1'b0);
        check("o_full_ok", {frame_ok_o, frame_drop_o}, 2'b10);
        expect_beats(start, 8'h60, 16, 16);

        // Backpressure: three committed 4-byte frames held, then released in order.
        m_if.tready = 1'b0;
        start = rx_q.size();
        send_frame(8'h71, 4, 1'b1, 1'b0);
        strobe(1'b0);
        send_frame(8'h81, 4, 1'b1, 1'b0);
        strobe(1'b0);
        send_frame(8'h91, 4, 1'b1, 1'b0);
        strobe(1'b0);
        check("b_cnt_ok_sat", 32'(cnt_ok_o), 3);
        check("b_hold_valid", 32'(m_if.tvalid), 1);
        check("b_hold_data0", {m_if.tlast, m_if.tdata}, 9'h071);
        tick(4);
        check("b_hold_data1", {m_if.tlast, m_if.tdata}, 9'h071);
        check("b_nothing_taken", 32'(rx_q.size()), 32'(start));
        m_if.tready = 1'b1;
        expect_beats(start, 8'h71, 12, 4);

        // Ignored strobes: idle RECV, and coincident with the tlast beat.
        do_reset();
        strobe(1'b0);
        check("i_idle_pulses", {frame_ok_o, frame_drop_o}, 0);
        check("i_idle_counters", {cnt_ok_o, cnt_crc_o, cnt_ovf_o}, 0);
        check("i_idle_ready", 32'(s_if.tready), 1);
        start = rx_q.size();
        send_frame(8'hD1, 2, 1'b1, 1'b1);
        check("i_last_pulses", {frame_ok_o, frame_drop_o}, 0);
        check("i_last_cnt", 32'(cnt_ok_o), 0);
        check("i_last_wait", 32'(s_if.tready), 0);
        tick(1);
        strobe(1'b0);
        check("i_commit_pulse", {frame_ok_o, frame_drop_o}, 2'b10);
        check("i_commit_cnt", 32'(cnt_ok_o), 1);
        expect_beats(start, 8'hD1, 2, 2);

        // Saturation over five good frames.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(8'hE0 + 8'(k)), 1, 1'b1, 1'b0);
            strobe(1'b0);
            check("s_cnt_ok", 32'(cnt_ok_o), (k < 3) ? k : 3);
        end
        tick(3);

        // Reset mid-frame with a committed frame still held back.
        m_if.tready = 1'b0;
        start = rx_q.size();
        send_frame(8'hB0, 2, 1'b1, 1'b0);
        strobe(1'b0);
        send_frame(8'hA0, 3, 1'b0, 1'b0);
        check("r_pending_valid", 32'(m_if.tvalid), 1);
        do_reset();
        m_if.tready = 1'b1;
        tick(5);
        check("r_no_stale_out", 32'(rx_q.size()), 32'(start));
        check("r_no_pulse", {frame_ok_o, frame_drop_o}, 0);
        send_frame(8'hC0, 1, 1'b1, 1'b0);
        strobe(1'b0);
        expect_beats(start, 8'hC0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
